// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-2 Booth multiplier controller.
// The optional debug ports are enabled by defining BOOTH_DBG_EN.
package booth_pkg;

    localparam int N_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2
    } booth_op_e;

    // Booth recoding: a 1->0 transition of the multiplier bits subtracts,
    // a 0->1 transition adds, and a run of equal bits needs no operation.
    function automatic booth_op_e booth_op(input logic q0, input logic q_m1);
        case ({q0, q_m1})
            2'b10:   return OP_SUB;
            2'b01:   return OP_ADD;
            default: return OP_NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_shift_stage.sv
// Combinational arithmetic right shift of the {A,Q,Q-1} register chain.
// The old Q-1 bit falls off the end of the chain and is not an input.
module booth_shift_stage #(
    parameter int N = 8
) (
    input  logic [N:0]   a_i,
    input  logic [N-1:0] q_i,
    output logic [N:0]   a_o,
    output logic [N-1:0] q_o,
    output logic         qm1_o
);

    assign qm1_o = q_i[0];
    assign q_o   = {a_i[0], q_i[N-1:1]};
    assign a_o   = {a_i[N], a_i[N:1]};

endmodule

// File: rtl/booth_mul_ctrl.sv
// Radix-2 Booth signed multiplier controller: FSM, iteration counter, add/sub.
// Define BOOTH_DBG_EN to expose dbg_state and dbg_count.
module booth_mul_ctrl
    import booth_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N-1:0]     multiplicand,
    input  logic [N-1:0]     multiplier,
    output logic             busy,
    output logic             done,
    output logic [2*N-1:0]   product
`ifdef BOOTH_DBG_EN
    ,
    output logic [1:0]               dbg_state,
    output logic [$clog2(N+1)-1:0]   dbg_count
`endif
);

    localparam int CW = $clog2(N + 1);

    state_e          state_q;
    logic [N:0]      a_q;
    logic [N-1:0]    q_q;
    logic            qm1_q;
    logic [N:0]      m_q;
    logic [CW-1:0]   count_q;
    logic            busy_q;
    logic            done_q;
    logic [2*N-1:0]  product_q;

    logic [N:0]      a_exec_d;
    logic [N:0]      a_shift_d;
    logic [N-1:0]    q_shift_d;
    logic            qm1_shift_d;

    // A is one bit wider than the operands so that subtracting M = -2^(N-1)
    // cannot overflow; all arithmetic wraps mod 2^(N+1).
    always_comb begin
        // NOTE: assign a default before the case so no path leaves a_exec_d unassigned (no latch).
        a_exec_d = a_q;
        case (booth_op(q_q[0], qm1_q))
            OP_SUB:  a_exec_d = a_q - m_q;
            OP_ADD:  a_exec_d = a_q + m_q;
            default: a_exec_d = a_q;
        endcase
    end

    booth_shift_stage #(.N(N)) u_shift (
        .a_i   (a_q),
        .q_i   (q_q),
        .a_o   (a_shift_d),
        .q_o   (q_shift_d),
        .qm1_o (qm1_shift_d)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            m_q       <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_q     <= '0;
                        q_q     <= multiplier;
                        qm1_q   <= 1'b0;
                        m_q     <= {multiplicand[N-1], multiplicand};
                        count_q <= CW'(N);
                        busy_q  <= 1'b1;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    a_q     <= a_exec_d;
                    state_q <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    a_q     <= a_shift_d;
                    q_q     <= q_shift_d;
                    qm1_q   <= qm1_shift_d;
                    count_q <= count_q - 1'b1;
                    state_q <= (count_q == CW'(1)) ? ST_DONE : ST_EXEC;
                end
                ST_DONE: begin
                    product_q <= {a_q[N-1:0], q_q};
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

`ifdef BOOTH_DBG_EN
    assign dbg_state = state_q;
    assign dbg_count = count_q;
`endif

endmodule
